// File: rtl/xadc_drp_responder.sv
// -----------------------------------------------------------------------------
// xadc_drp_responder
//
// Behavioural stand-in for the XADC dynamic reconfiguration port (DRP). A DRP
// initiator talks to it exactly as it would to the XADC primitive. Conversion
// samples come from an external source. Each sample is held for a fixed
// conversion time and then stored left-justified in its status register.
// The completion is announced with eoc_out/channel_out.
//
// Ports
//   clk          single clock for DRP and conversion logic
//   rst_n        synchronous, active-low reset
//   daddr_in     DRP address (7 bits)
//   den_in       DRP enable strobe
//   dwe_in       DRP write enable, qualified by den_in
//   di_in        DRP write data
//   do_out       DRP read data, non-zero only in the drdy_out cycle of a read
//   drdy_out     DRP ready, one-cycle pulse DRP_LATENCY cycles after accept
//   busy_out     conversion in progress
//   eoc_out      end-of-conversion, one-cycle pulse
//   channel_out  channel of the last completed conversion
//   sample_valid new sample offered
//   sample_ch    channel of the offered sample
//   sample_data  offered sample value
//   overrun      sticky: sample dropped while busy, or den_in while DRP busy
//
// Register map
//   0x00-0x1F  status, read-only (writes acknowledged, ignored)
//   0x40-0x42  config, read/write
//   others     read 0x0000, writes acknowledged, ignored
// -----------------------------------------------------------------------------
module xadc_drp_responder #(
    parameter int DRP_LATENCY = 2,   // 1..15
    parameter int CONV_CYCLES = 26,  // 2..255
    parameter int SAMPLE_W    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          daddr_in,
    input  logic                den_in,
    input  logic                dwe_in,
    input  logic [15:0]         di_in,
    output logic [15:0]         do_out,
    output logic                drdy_out,
    output logic                busy_out,
    output logic                eoc_out,
    output logic [4:0]          channel_out,
    input  logic                sample_valid,
    input  logic [4:0]          sample_ch,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } conv_state_t;

    // ------------------------------------------------------------------ DRP --
    logic                r_pend;
    logic [3:0]          r_lat_cnt;
    logic [6:0]          r_addr;
    logic                r_we;
    logic [15:0]         r_wdata;
    logic [15:0]         r_rdata;

    logic [15:0]         r_status [32];
    logic [15:0]         r_cfg    [3];

    logic                w_drdy;
    logic                w_accept;
    logic [15:0]         w_read_val;
    logic                w_cfg_wr;

    // ----------------------------------------------------------- conversion --
    conv_state_t         r_state;
    conv_state_t         w_next_state;
    logic [7:0]          r_conv_cnt;
    logic [4:0]          r_smp_ch;
    logic [SAMPLE_W-1:0] r_smp_data;
    logic [4:0]          r_channel;
    logic                r_overrun;
    logic                w_busy;
    logic                w_eoc;
    logic [15:0]         w_sample_word;

    // The transaction completes when the latency counter has run down; a new
    // strobe is accepted in that same cycle, so accept and complete overlap.
    assign w_drdy   = r_pend && (r_lat_cnt == 4'd0);
    assign w_accept = den_in && (!r_pend || w_drdy);
    assign w_cfg_wr = w_drdy && r_we && (r_addr >= 7'h40) && (r_addr <= 7'h42);

    // Read data is captured at acceptance, so a status update landing on the
    // same edge is not visible to that read.
    always_comb begin
        w_read_val = 16'h0000;
        if (daddr_in[6:5] == 2'b00) begin
            w_read_val = r_status[daddr_in[4:0]];
        end else if ((daddr_in >= 7'h40) && (daddr_in <= 7'h42)) begin
            w_read_val = r_cfg[daddr_in[1:0]];
        end
    end

    // NOTE: sequential state is written with <= only so every flop samples the
    // pre-edge values; mixing = here would make results depend on block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_lat_cnt <= 4'd0;
            r_addr    <= 7'd0;
            r_we      <= 1'b0;
            r_wdata   <= 16'h0000;
            r_rdata   <= 16'h0000;
        end else if (w_accept) begin
            r_pend    <= 1'b1;
            r_lat_cnt <= 4'(DRP_LATENCY - 1);
            r_addr    <= daddr_in;
            r_we      <= dwe_in;
            r_wdata   <= di_in;
            r_rdata   <= dwe_in ? 16'h0000 : w_read_val;
        end else if (w_drdy) begin
            r_pend    <= 1'b0;
        end else if (r_pend) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
        end
    end

    // NOTE: the register file is reset explicitly because reset must make
    // every status/config location read back as 0x0000.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_status[i] <= 16'h0000;
            for (int i = 0; i < 3; i++)  r_cfg[i]    <= 16'h0000;
        end else begin
            if (w_cfg_wr) begin
                r_cfg[r_addr[1:0]] <= r_wdata;
            end
            if (r_state == S_DONE) begin
                r_status[r_smp_ch] <= w_sample_word;
            end
        end
    end

    assign do_out   = w_drdy ? r_rdata : 16'h0000;
    assign drdy_out = w_drdy;

    // ------------------------------------------------------- conversion FSM --
    assign w_sample_word = 16'(r_smp_data) << (16 - SAMPLE_W);

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_eoc        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_valid) w_next_state = S_CONV;
            end
            S_CONV: begin
                w_busy = 1'b1;
                if (r_conv_cnt == 8'(CONV_CYCLES - 1)) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_eoc        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_conv_cnt <= 8'd0;
            r_smp_ch   <= 5'd0;
            r_smp_data <= '0;
            r_channel  <= 5'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == S_IDLE) && sample_valid) begin
                r_smp_ch   <= sample_ch;
                r_smp_data <= sample_data;
                r_conv_cnt <= 8'd0;
            end else if (r_state == S_CONV) begin
                r_conv_cnt <= r_conv_cnt + 8'd1;
            end

            if (r_state == S_DONE) begin
                r_channel <= r_smp_ch;
            end

            // Dropped samples and strobes arriving while a transaction is
            // still counting down are both reported through one sticky flag.
            if ((sample_valid && (r_state != S_IDLE)) ||
                (den_in && r_pend && !w_drdy)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign busy_out    = w_busy;
    assign eoc_out     = w_eoc;
    // channel_out already shows the new channel during the DONE cycle.
    assign channel_out = (r_state == S_DONE) ? r_smp_ch : r_channel;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_xadc_drp_responder.sv
module tb_xadc_drp_responder;

    localparam int LAT  = 2;
    localparam int CONV = 26;
    localparam int SW   = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    daddr_in;
    logic          den_in;
    logic          dwe_in;
    logic [15:0]   di_in;
    logic [15:0]   do_out;
    logic          drdy_out;
    logic          busy_out;
    logic          eoc_out;
    logic [4:0]    channel_out;
    logic          sample_valid;
    logic [4:0]    sample_ch;
    logic [SW-1:0] sample_data;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register contents as the map defines them.
    logic [15:0] stat_m [32];
    logic [15:0] cfg_m  [3];

    xadc_drp_responder #(
        .DRP_LATENCY(LAT),
        .CONV_CYCLES(CONV),
        .SAMPLE_W   (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .daddr_in    (daddr_in),
        .den_in      (den_in),
        .dwe_in      (dwe_in),
        .di_in       (di_in),
        .do_out      (do_out),
        .drdy_out    (drdy_out),
        .busy_out    (busy_out),
        .eoc_out     (eoc_out),
        .channel_out (channel_out),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch),
        .sample_data (sample_data),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] model_read(input logic [6:0] a);
        if (a < 7'h20) return stat_m[a[4:0]];
        if (a >= 7'h40 && a <= 7'h42) return cfg_m[int'(a) - 64];
        return 16'h0000;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [15:0] d);
        if (a >= 7'h40 && a <= 7'h42) cfg_m[int'(a) - 64] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) stat_m[i] = 16'h0000;
        for (int i = 0; i < 3; i++)  cfg_m[i]  = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete DRP transaction with latency and pulse-shape checks.
    task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                       output logic [15:0] rd);
        int n;
        daddr_in = a; dwe_in = we; di_in = d; den_in = 1'b1;
        tick();
        den_in = 1'b0; dwe_in = 1'b0;
        n = 1;
        while (drdy_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (drdy_out !== 1'b1 || n != LAT) begin
            errors++;
            $display("FAIL drp_latency addr=%h got %0d cycles (drdy=%b) expected %0d", a, n, drdy_out, LAT);
        end
        rd = do_out;
        if (we) begin
            checks++;
            if (do_out !== 16'h0000) begin
                errors++;
                $display("FAIL drp_write_do addr=%h got %h expected 0000", a, do_out);
            end
            model_write(a, d);
        end
        tick();
        checks++;
        if (drdy_out !== 1'b0 || do_out !== 16'h0000) begin
            errors++;
            $display("FAIL drp_pulse addr=%h got drdy=%b do=%h expected drdy=0 do=0000", a, drdy_out, do_out);
        end
    endtask

    task automatic drp_read_check(input logic [6:0] a);
        logic [15:0] rd;
        drp(a, 1'b0, 16'h0000, rd);
        checks++;
        if (rd !== model_read(a)) begin
            errors++;
            $display("FAIL drp_read addr=%h got %h expected %h", a, rd, model_read(a));
        end
    endtask

    // Run one conversion; optionally read the same channel in the DONE cycle.
    task automatic convert(input logic [4:0] ch, input logic [SW-1:0] data, input bit read_at_done);
        int n;
        int early_eoc;
        logic [15:0] old;
        old = stat_m[ch];
        sample_ch = ch; sample_data = data; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0; sample_data = SW'($urandom); sample_ch = 5'($urandom);
        n = 0; early_eoc = 0;
        while (busy_out === 1'b1 && n < 300) begin
            if (eoc_out !== 1'b0) early_eoc++;
            n++;
            tick();
        end
        checks++;
        if (n != CONV || early_eoc != 0) begin
            errors++;
            $display("FAIL busy_len ch=%h got %0d cycles (eoc during busy %0d) expected %0d", ch, n, early_eoc, CONV);
        end
        checks++;
        if (eoc_out !== 1'b1 || channel_out !== ch) begin
            errors++;
            $display("FAIL eoc ch got eoc=%b ch=%h expected eoc=1 ch=%h", eoc_out, channel_out, ch);
        end
        stat_m[ch] = {data, 4'h0};
        if (read_at_done) begin
            daddr_in = {2'b00, ch}; dwe_in = 1'b0; den_in = 1'b1;
            tick();
            den_in = 1'b0;
            tick();
            checks++;
            if (drdy_out !== 1'b1 || do_out !== old) begin
                errors++;
                $display("FAIL read_at_done ch=%h got drdy=%b do=%h expected drdy=1 do=%h", ch, drdy_out, do_out, old);
            end
        end
        tick();
        checks++;
        if (eoc_out !== 1'b0 || busy_out !== 1'b0 || channel_out !== ch) begin
            errors++;
            $display("FAIL post_done got eoc=%b busy=%b ch=%h expected 0 0 %h", eoc_out, busy_out, channel_out, ch);
        end
        drp_read_check({2'b00, ch});
    endtask

    task automatic check_overrun(input logic exp, input string name);
        checks++;
        if (overrun !== exp) begin
            errors++;
            $display("FAIL %s overrun got %b expected %b", name, overrun, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({do_out, drdy_out, busy_out, eoc_out, channel_out, overrun} !== '0) begin
            errors++;
            $display("FAIL %s got do=%h drdy=%b busy=%b eoc=%b ch=%h ovr=%b expected all 0",
                     name, do_out, drdy_out, busy_out, eoc_out, channel_out, overrun);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        // Strobes asserted during reset must be ignored.
        rst_n = 1'b0; den_in = 1'b1; sample_valid = 1'b1; daddr_in = 7'h16;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outputs_zero("reset_outputs");
        end
        den_in = 1'b0; sample_valid = 1'b0;
        rst_n = 1'b1;
        model_clear();
        tick();
        check_outputs_zero("after_reset");
        drp_read_check(7'h16);
    endtask

    task automatic test_conversion();
        convert(5'h16, 12'hABC, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] ch;
            ch = 5'($urandom_range(0, 31));
            if (ch == 5'h16) ch = 5'h15;
            convert(ch, SW'($urandom), i[0]);
        end
        check_overrun(1'b0, "conversion");
    endtask

    task automatic test_conv_after_done();
        int n;
        sample_ch = 5'h03; sample_data = SW'($urandom); sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (eoc_out !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        stat_m[3] = {sample_data, 4'h0};
        tick();
        // Cycle right after DONE: a new sample must be accepted.
        convert(5'h07, SW'($urandom), 1'b0);
        drp_read_check(7'h03);
        check_overrun(1'b0, "conv_after_done");
    endtask

    task automatic test_config_rw();
        logic [15:0] rd;
        drp(7'h41, 1'b1, 16'h1234, rd);
        drp_read_check(7'h41);
        for (int i = 0; i < 14; i++) begin
            logic [6:0] a;
            case ($urandom_range(0, 2))
                0: a = 7'(64 + $urandom_range(0, 2));
                1: a = 7'($urandom_range(32, 63));
                default: a = 7'($urandom_range(67, 127));
            endcase
            if ($urandom_range(0, 1) == 1) drp(a, 1'b1, 16'($urandom), rd);
            else drp_read_check(a);
        end
        for (int a = 64; a <= 66; a++) drp_read_check(7'(a));
    endtask

    task automatic test_status_readonly();
        logic [15:0] rd;
        drp(7'h16, 1'b1, 16'hFFFF, rd);
        drp_read_check(7'h16);
        checks++;
        if (stat_m[5'h16] !== 16'hABC0) begin
            errors++;
            $display("FAIL status_model got %h expected abc0", stat_m[5'h16]);
        end
        check_overrun(1'b0, "status_readonly");
    endtask

    task automatic test_back_to_back();
        daddr_in = 7'h41; dwe_in = 1'b0; den_in = 1'b1;
        tick();
        den_in = 1'b0;
        tick();
        checks++;
        if (drdy_out !== 1'b1 || do_out !== model_read(7'h41)) begin
            errors++;
            $display("FAIL b2b_first got drdy=%b do=%h expected 1 %h", drdy_out, do_out, model_read(7'h41));
        end
        daddr_in = 7'h16; den_in = 1'b1;
        tick();
        den_in = 1'b0;
        checks++;
        if (drdy_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got drdy=%b expected 0", drdy_out);
        end
        tick();
        checks++;
        if (drdy_out !== 1'b1 || do_out !== model_read(7'h16)) begin
            errors++;
            $display("FAIL b2b_second got drdy=%b do=%h expected 1 %h", drdy_out, do_out, model_read(7'h16));
        end
        tick();
        check_overrun(1'b0, "back_to_back");
    endtask

    task automatic test_overrun_drp();
        int pulses;
        check_overrun(1'b0, "overrun_drp_pre");
        daddr_in = 7'h40; dwe_in = 1'b0; den_in = 1'b1;
        tick();
        daddr_in = 7'h42;
        tick();
        den_in = 1'b0;
        checks++;
        if (drdy_out !== 1'b1 || do_out !== model_read(7'h40)) begin
            errors++;
            $display("FAIL overrun_drp_first got drdy=%b do=%h expected 1 %h", drdy_out, do_out, model_read(7'h40));
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (drdy_out !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL overrun_drp_extra got %0d pulses expected 0", pulses);
        end
        check_overrun(1'b1, "overrun_drp");
    endtask

    task automatic test_overrun_sample();
        logic [4:0]    ch;
        logic [SW-1:0] d1;
        int eocs;
        check_overrun(1'b0, "overrun_sample_pre");
        ch = 5'($urandom_range(0, 31));
        d1 = SW'($urandom);
        sample_ch = ch; sample_data = d1; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (5) tick();
        sample_data = ~d1; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_overrun(1'b1, "overrun_sample");
        eocs = 0;
        for (int i = 0; i < 60; i++) begin
            if (eoc_out === 1'b1) eocs++;
            tick();
        end
        checks++;
        if (eocs != 1) begin
            errors++;
            $display("FAIL overrun_sample_eoc got %0d pulses expected 1", eocs);
        end
        stat_m[ch] = {d1, 4'h0};
        drp_read_check({2'b00, ch});
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd;
        int events;
        drp(7'h41, 1'b1, 16'($urandom_range(1, 65535)), rd);
        sample_ch = 5'h09; sample_data = SW'($urandom); sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (10) tick();
        daddr_in = 7'h41; dwe_in = 1'b0; den_in = 1'b1;
        tick();
        den_in = 1'b0;
        rst_n = 1'b0;
        tick();
        check_outputs_zero("abort_in_reset");
        rst_n = 1'b1;
        model_clear();
        events = 0;
        for (int i = 0; i < 40; i++) begin
            if (drdy_out !== 1'b0 || eoc_out !== 1'b0 || busy_out !== 1'b0) events++;
            tick();
        end
        checks++;
        if (events != 0) begin
            errors++;
            $display("FAIL abort_events got %0d active cycles expected 0", events);
        end
        for (int a = 0; a < 32; a++) drp_read_check(7'(a));
        for (int a = 64; a <= 66; a++) drp_read_check(7'(a));
        check_outputs_zero("abort_final");
    endtask

    initial begin
        rst_n = 1'b0; daddr_in = '0; den_in = 1'b0; dwe_in = 1'b0; di_in = '0;
        sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
        model_clear();
        test_reset();
        test_conversion();
        test_conv_after_done();
        test_config_rw();
        test_status_readonly();
        test_back_to_back();
        test_overrun_drp();
        apply_reset();
        test_overrun_sample();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
